// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the SPARC V8 fetch/PC sequencer: extender selects,
// instruction field constants, Bicc condition codes and the sequencer states.
package branch_sequencer_pkg;

    localparam logic [2:0] SE_SIMM13   = 3'd0;
    localparam logic [2:0] SE_SIMM22   = 3'd1;
    localparam logic [2:0] SE_SIMM30   = 3'd2;
    localparam logic [2:0] SE_DISP30X4 = 3'd3;
    localparam logic [2:0] SE_IMM22    = 3'd4;
    localparam logic [2:0] SE_DISP22X4 = 3'd5;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_JMPL = 6'b111000;

    localparam logic [3:0] COND_BN   = 4'h0;
    localparam logic [3:0] COND_BE   = 4'h1;
    localparam logic [3:0] COND_BLE  = 4'h2;
    localparam logic [3:0] COND_BL   = 4'h3;
    localparam logic [3:0] COND_BLEU = 4'h4;
    localparam logic [3:0] COND_BCS  = 4'h5;
    localparam logic [3:0] COND_BNEG = 4'h6;
    localparam logic [3:0] COND_BVS  = 4'h7;
    localparam logic [3:0] COND_BA   = 4'h8;
    localparam logic [3:0] COND_BNE  = 4'h9;
    localparam logic [3:0] COND_BG   = 4'hA;
    localparam logic [3:0] COND_BGE  = 4'hB;
    localparam logic [3:0] COND_BGU  = 4'hC;
    localparam logic [3:0] COND_BCC  = 4'hD;
    localparam logic [3:0] COND_BPOS = 4'hE;
    localparam logic [3:0] COND_BVC  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_UPDATE = 2'd3
    } seq_state_t;

    // Format-3 with i=1 wants simm13, which is also the fallback encoding.
    function automatic logic [2:0] se_sel_for(input logic [1:0] op, input logic [2:0] op2);
        logic [2:0] sel;
        sel = SE_SIMM13;
        if (op == OP_CALL)
            sel = SE_DISP30X4;
        else if (op == OP_FMT2 && op2 == OP2_BICC)
            sel = SE_DISP22X4;
        else if (op == OP_FMT2 && op2 == OP2_SETHI)
            sel = SE_IMM22;
        return sel;
    endfunction

endpackage

// File: rtl/branch_sequencer_cond.sv
// Bicc condition evaluator: cond[3] inverts the base test selected by cond[2:0].
module bicc_cond_eval
    import branch_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic n, z, v, c;
    logic base;

    assign n = icc[3];
    assign z = icc[2];
    assign v = icc[1];
    assign c = icc[0];

    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            COND_BE[2:0]:   base = z;
            COND_BLE[2:0]:  base = z | (n ^ v);
            COND_BL[2:0]:   base = n ^ v;
            COND_BLEU[2:0]: base = c | z;
            COND_BCS[2:0]:  base = c;
            COND_BNEG[2:0]: base = n;
            COND_BVS[2:0]:  base = v;
            default:        base = 1'b0;
        endcase
        taken = base ^ cond[3];
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/PC sequencer: one instruction in flight, PC/nPC delay-slot update,
// Bicc/CALL/JMPL targets and annulled-slot squashing.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] ir,
    output logic        issue,
    input  logic        exec_done,
    input  logic [3:0]  icc,
    input  logic [31:0] jmpl_target,
    output logic [2:0]  se_sel,
    input  logic [31:0] ext_imm,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        annulled
);

    seq_state_t state, state_nxt;

    logic [3:0]  icc_q;
    logic [29:0] jt_q;
    logic [31:0] imm_q;

    logic        fetch_take, exec_take;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [3:0]  cond;
    logic        a_bit;
    logic        is_bicc, is_call, is_jmpl;
    logic        cond_taken;
    logic        br_taken, br_annul;
    logic [31:0] br_target;

    assign op    = ir[31:30];
    assign op2   = ir[24:22];
    assign op3   = ir[24:19];
    assign cond  = ir[28:25];
    assign a_bit = ir[29];

    assign is_bicc = (op == OP_FMT2)  && (op2 == OP2_BICC);
    assign is_call = (op == OP_CALL);
    assign is_jmpl = (op == OP_ARITH) && (op3 == OP3_JMPL);

    // se_sel stays valid through EXEC so ext_imm is still right when exec_done lands.
    assign se_sel     = se_sel_for(op, op2);
    assign fetch_addr = pc;
    assign issue      = (state == ST_DECODE);

    // fetch_req is registered, so the first cycle out of reset never accepts an ack.
    assign fetch_take = (state == ST_FETCH) && fetch_req && fetch_ack;
    assign exec_take  = (state == ST_EXEC) && exec_done;

    bicc_cond_eval u_cond (
        .cond  (cond),
        .icc   (icc_q),
        .taken (cond_taken)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (fetch_take) state_nxt = annulled ? ST_UPDATE : ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   if (exec_take) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = ST_FETCH;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // A squashed slot sequences like a plain instruction whatever its encoding.
    always_comb begin
        br_taken  = 1'b0;
        br_annul  = 1'b0;
        br_target = pc + imm_q;
        if (!annulled) begin
            if (is_call) begin
                br_taken = 1'b1;
            end else if (is_jmpl) begin
                br_taken  = 1'b1;
                br_target = {jt_q, 2'b00};
            end else if (is_bicc) begin
                br_taken = cond_taken;
                br_annul = a_bit && (!cond_taken || cond == COND_BA);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            npc       <= RESET_PC + 32'd4;
            ir        <= '0;
            fetch_req <= 1'b0;
            annulled  <= 1'b0;
            icc_q     <= '0;
            jt_q      <= '0;
            imm_q     <= '0;
        end else begin
            state     <= state_nxt;
            fetch_req <= (state_nxt == ST_FETCH);
            if (fetch_take)
                ir <= fetch_data;
            if (exec_take) begin
                icc_q <= icc;
                jt_q  <= jmpl_target[31:2];
                imm_q <= ext_imm;
            end
            if (state == ST_UPDATE) begin
                pc       <= npc;
                npc      <= br_taken ? br_target : npc + 32'd4;
                annulled <= br_annul;
            end
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: acts as instruction memory, datapath and extender,
// and checks PC/nPC/annul/issue behaviour against an instruction-level model.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = '0;
    logic [31:0] ir;
    logic        issue;
    logic        exec_done = 1'b0;
    logic [3:0]  icc = '0;
    logic [31:0] jmpl_target = '0;
    logic [2:0]  se_sel;
    logic [31:0] ext_imm;
    logic [31:0] pc, npc;
    logic        annulled;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_issue = 0;
    int got_issue = 0;

    logic [31:0] m_pc, m_npc;
    logic        m_annul;

    localparam logic [31:0] ADD_W = 32'h8600_4002;

    branch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_data  (fetch_data),
        .ir          (ir),
        .issue       (issue),
        .exec_done   (exec_done),
        .icc         (icc),
        .jmpl_target (jmpl_target),
        .se_sel      (se_sel),
        .ext_imm     (ext_imm),
        .pc          (pc),
        .npc         (npc),
        .annulled    (annulled)
    );

    always #5 clk = ~clk;

    // Stand-in for the existing immediate extender.
    always_comb begin
        case (se_sel)
            3'd0:    ext_imm = {{19{ir[12]}}, ir[12:0]};
            3'd1:    ext_imm = {{10{ir[21]}}, ir[21:0]};
            3'd2:    ext_imm = {{2{ir[29]}}, ir[29:0]};
            3'd3:    ext_imm = {ir[29:0], 2'b00};
            3'd4:    ext_imm = {ir[21:0], 10'd0};
            3'd5:    ext_imm = {{8{ir[21]}}, ir[21:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c, r;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cond)
            4'h8: r = 1'b1;          4'h0: r = 1'b0;
            4'h9: r = !z;            4'h1: r = z;
            4'hA: r = !(z | (n ^ v)); 4'h2: r = z | (n ^ v);
            4'hB: r = !(n ^ v);      4'h3: r = n ^ v;
            4'hC: r = !(c | z);      4'h4: r = c | z;
            4'hD: r = !c;            4'h5: r = c;
            4'hE: r = !n;            4'h6: r = n;
            4'hF: r = !v;            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] ref_sel(input logic [31:0] w);
        if (w[31:30] == 2'b01) return 3'd3;
        if (w[31:30] == 2'b00 && w[24:22] == 3'b010) return 3'd5;
        if (w[31:30] == 2'b00 && w[24:22] == 3'b100) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [31:0] bicc(input logic a, input logic [3:0] cond, input logic [21:0] disp);
        return {2'b00, a, cond, 3'b010, disp};
    endfunction

    function automatic logic [31:0] jmpl_w();
        return {2'b10, 5'd0, 6'b111000, 5'd1, 1'b1, 13'd0};
    endfunction

    // Instruction-level model: where does control go after this instruction?
    function automatic void model_step(input logic [31:0] w, input logic [3:0] f, input logic [31:0] jt);
        logic        taken, ann;
        logic [31:0] tgt;
        taken = 1'b0; ann = 1'b0; tgt = '0;
        if (!m_annul) begin
            if (w[31:30] == 2'b01) begin
                taken = 1'b1;
                tgt   = m_pc + {w[29:0], 2'b00};
            end else if (w[31:30] == 2'b10 && w[24:19] == 6'b111000) begin
                taken = 1'b1;
                tgt   = jt & 32'hFFFF_FFFC;
            end else if (w[31:30] == 2'b00 && w[24:22] == 3'b010) begin
                taken = ref_cond(w[28:25], f);
                tgt   = m_pc + {{8{w[21]}}, w[21:0], 2'b00};
                ann   = w[29] && (!taken || w[28:25] == 4'h8);
            end
        end
        m_pc    = m_npc;
        m_npc   = taken ? tgt : m_npc + 32'd4;
        m_annul = ann;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0: begin w[31:30] = 2'b10; if (w[24:19] == 6'b111000) w[19] = 1'b1; end
            1: begin w[31:30] = 2'b00; w[24:22] = 3'b100; end
            2, 3: begin w[31:30] = 2'b00; w[24:22] = 3'b010; end
            4: w[31:30] = 2'b01;
            5: begin w[31:30] = 2'b10; w[24:19] = 6'b111000; end
            6: w[31:30] = 2'b11;
            default: begin w[31:30] = 2'b00; w[24:22] = 3'b000; end
        endcase
        return w;
    endfunction

    task automatic wait_fetch();
        int n = 0;
        while (!fetch_req && n < 16) begin
            tick();
            n++;
        end
        if (!fetch_req) begin
            chk("fetch_req_timeout", {31'd0, fetch_req}, 32'd1);
            finish_run();
            $fatal(1, "fetch_req never asserted");
        end
    endtask

    task automatic fetch_at(input logic [31:0] lit);
        wait_fetch();
        chk("fetch_addr_lit", fetch_addr, lit);
    endtask

    task automatic run_instr(input logic [31:0] w, input logic [3:0] f, input logic [31:0] jt,
                             input int ack_dly, input int ex_dly, input bit noise);
        wait_fetch();
        repeat (ack_dly) tick();
        fetch_ack = 1'b1; fetch_data = w;
        tick();
        fetch_ack = 1'b0; fetch_data = $urandom;
        if (!m_annul) begin
            chk("issue_strobe", {31'd0, issue}, 32'd1);
            chk("ir", ir, w);
            chk("se_sel", {29'd0, se_sel}, {29'd0, ref_sel(w)});
            exp_issue++;
            if (noise) begin exec_done = 1'b1; jmpl_target = $urandom; icc = 4'($urandom); end
            tick();
            exec_done = 1'b0;
            chk("issue_one_cycle", {31'd0, issue}, 32'd0);
            for (int i = 0; i < ex_dly; i++) begin
                if (noise) begin fetch_ack = 1'b1; fetch_data = $urandom; end
                tick();
                fetch_ack = 1'b0;
            end
            exec_done = 1'b1; icc = f; jmpl_target = jt;
            tick();
            exec_done = 1'b0; icc = 4'($urandom); jmpl_target = $urandom;
        end else begin
            chk("annul_no_issue", {31'd0, issue}, 32'd0);
        end
        model_step(w, f, jt);
    endtask

    // Per-cycle check of architectural state whenever a fetch is outstanding.
    always @(posedge clk) begin
        #1;
        if (reset_n && fetch_req) begin
            chk("mon_pc", pc, m_pc);
            chk("mon_fetch_addr", fetch_addr, m_pc);
            chk("mon_npc", npc, m_npc);
            chk("mon_annulled", {31'd0, annulled}, {31'd0, m_annul});
        end
        if (reset_n && issue) begin
            got_issue++;
            if (m_annul) chk("mon_issue_in_annul", {31'd0, issue}, 32'd0);
        end
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish");
        finish_run();
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_npc", npc, 32'h4);
        chk("rst_ir", ir, 32'h0);
        chk("rst_issue", {31'd0, issue}, 32'd0);
        chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("rst_se_sel", {29'd0, se_sel}, 32'd0);
        chk("rst_annulled", {31'd0, annulled}, 32'd0);
        reset_n = 1'b1;
        chk("release_no_req", {31'd0, fetch_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, fetch_req}, 32'd1);
        chk("first_addr", fetch_addr, 32'h0);

        // Straight line, then BNE / BE,a / JMPL / BA,a scenarios.
        fetch_at(32'h00); run_instr(ADD_W, 4'h0, 32'h0, 0, 1, 0);
        fetch_at(32'h04); run_instr(ADD_W, 4'h0, 32'h0, 0, 1, 0);
        fetch_at(32'h08); run_instr(ADD_W, 4'h0, 32'h0, 0, 1, 0);
        fetch_at(32'h0C); run_instr(ADD_W, 4'h0, 32'h0, 1, 0, 0);
        fetch_at(32'h10); run_instr(bicc(1'b0, 4'h9, 22'd3), 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h14); run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h1C); run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h20); run_instr(bicc(1'b1, 4'h1, 22'd8), 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h24);
        chk("be_slot_annulled", {31'd0, annulled}, 32'd1);
        run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h28); run_instr(jmpl_w(), 4'h0, 32'h103, 0, 2, 0);
        fetch_at(32'h2C); run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h100); run_instr(jmpl_w(), 4'h0, 32'h40, 0, 0, 0);
        fetch_at(32'h104); run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h40); run_instr(bicc(1'b1, 4'h8, 22'h3FFFFC), 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h44);
        chk("ba_slot_annulled", {31'd0, annulled}, 32'd1);
        run_instr(ADD_W, 4'h0, 32'h0, 2, 0, 0);
        fetch_at(32'h30); run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 1);

        // Reset while the datapath is still executing.
        wait_fetch();
        fetch_ack = 1'b1; fetch_data = ADD_W;
        tick();
        fetch_ack = 1'b0;
        exp_issue++;
        tick(); tick();
        reset_n = 1'b0;
        m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0;
        #1;
        chk("midexec_rst_pc", pc, 32'h0);
        chk("midexec_rst_npc", npc, 32'h4);
        chk("midexec_rst_req", {31'd0, fetch_req}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("midexec_req", {31'd0, fetch_req}, 32'd1);
        chk("midexec_addr", fetch_addr, 32'h0);

        // CALL with the largest displacement wraps to the word below zero.
        run_instr({2'b01, 30'h3FFF_FFFF}, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h4);
        chk("call_npc", npc, 32'hFFFF_FFFC);
        run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'h0);
        run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
        fetch_at(32'h0);

        // Every condition code under random flags and annul bits.
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 3; k++) begin
                run_instr(bicc(1'($urandom), 4'(c), 22'($urandom_range(0, 63)) - 22'd32),
                          4'($urandom), 32'h0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
                run_instr(ADD_W, 4'h0, 32'h0, 0, 0, 0);
            end
        end

        for (int i = 0; i < 300; i++) begin
            run_instr(rand_insn(), 4'($urandom), $urandom, $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom));
        end

        wait_fetch();
        chk("issue_count", got_issue, exp_issue);
        finish_run();
        $finish;
    end

endmodule
